// File: rtl/branch_resolver_pkg.sv
// Shared processor definitions: control-transfer op encodings, branch funct3
// codes and the ALU operation set used by the execute stage.
package branch_resolver_pkg;

    typedef enum logic [1:0] {
        OP_BRANCH = 2'b00,
        OP_JAL    = 2'b01,
        OP_JALR   = 2'b10,
        OP_NONE   = 2'b11
    } op_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_RSV2 = 3'b010;
    localparam logic [2:0] F3_RSV3 = 3'b011;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    // Byte distance from a control-transfer instruction to its fall-through.
    localparam int unsigned INSN_BYTES = 4;

endpackage

// File: rtl/branch_resolver_cond.sv
// Combinational decode of a branch funct3 into a taken condition using the
// comparator flags; reserved funct3 codes report illegal with cond forced low.
module branch_cond
    import branch_resolver_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       flag_equal,
    input  logic       flag_not_equal,
    input  logic       flag_greater,
    input  logic       flag_less,
    input  logic       flag_u_greater,
    input  logic       flag_u_less,
    output logic       cond,
    output logic       illegal
);

    always_comb begin
        cond    = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  cond = flag_equal;
            F3_BNE:  cond = flag_not_equal;
            F3_BLT:  cond = flag_less;
            F3_BGE:  cond = flag_greater | flag_equal;
            F3_BLTU: cond = flag_u_less;
            F3_BGEU: cond = flag_u_greater | flag_equal;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// One-entry registered branch/jump resolution stage with valid/ready on both
// sides. Optional taken/not-taken counters under BRANCH_RESOLVER_STATS_EN.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          op,
    input  logic [2:0]          funct3,
    input  logic [WORDSIZE-1:0] pc,
    input  logic [WORDSIZE-1:0] imm,
    input  logic [WORDSIZE-1:0] rs1,
    input  logic                flag_equal,
    input  logic                flag_not_equal,
    input  logic                flag_greater,
    input  logic                flag_less,
    input  logic                flag_u_greater,
    input  logic                flag_u_less,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                taken,
    output logic [WORDSIZE-1:0] target,
    output logic [WORDSIZE-1:0] link,
    output logic                misaligned,
`ifdef BRANCH_RESOLVER_STATS_EN
    output logic [31:0]         stat_taken,
    output logic [31:0]         stat_not_taken,
`endif
    output logic                illegal
);

    logic                cond;
    logic                cond_illegal;
    logic                accept;

    logic                taken_calc;
    logic                illegal_calc;
    logic                misaligned_calc;
    logic [WORDSIZE-1:0] target_calc;
    logic [WORDSIZE-1:0] link_calc;
    logic [WORDSIZE-1:0] pc_rel;
    logic [WORDSIZE-1:0] rs1_rel;

    logic                out_valid_q, out_valid_d;
    logic                taken_q,     taken_d;
    logic                illegal_q,   illegal_d;
    logic                misaligned_q, misaligned_d;
    logic [WORDSIZE-1:0] target_q,    target_d;
    logic [WORDSIZE-1:0] link_q,      link_d;

    branch_cond u_cond (
        .funct3         (funct3),
        .flag_equal     (flag_equal),
        .flag_not_equal (flag_not_equal),
        .flag_greater   (flag_greater),
        .flag_less      (flag_less),
        .flag_u_greater (flag_u_greater),
        .flag_u_less    (flag_u_less),
        .cond           (cond),
        .illegal        (cond_illegal)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // All sums wrap silently at WORDSIZE bits.
    always_comb begin
        link_calc    = pc + WORDSIZE'(INSN_BYTES);
        pc_rel       = pc + imm;
        rs1_rel      = rs1 + imm;
        taken_calc   = 1'b0;
        illegal_calc = 1'b0;
        target_calc  = link_calc;
        case (op_e'(op))
            OP_BRANCH: begin
                illegal_calc = cond_illegal;
                taken_calc   = cond && !cond_illegal;
                target_calc  = taken_calc ? pc_rel : link_calc;
            end
            OP_JAL: begin
                taken_calc  = 1'b1;
                target_calc = pc_rel;
            end
            OP_JALR: begin
                taken_calc  = 1'b1;
                target_calc = {rs1_rel[WORDSIZE-1:1], 1'b0};
            end
            default: begin
                taken_calc  = 1'b0;
                target_calc = link_calc;
            end
        endcase
        misaligned_calc = taken_calc && (target_calc[1:0] != 2'b00);
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        taken_d      = taken_q;
        illegal_d    = illegal_q;
        misaligned_d = misaligned_q;
        target_d     = target_q;
        link_d       = link_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            taken_d      = taken_calc;
            illegal_d    = illegal_calc;
            misaligned_d = misaligned_calc;
            target_d     = target_calc;
            link_d       = link_calc;
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            taken_q      <= 1'b0;
            illegal_q    <= 1'b0;
            misaligned_q <= 1'b0;
            target_q     <= '0;
            link_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            taken_q      <= taken_d;
            illegal_q    <= illegal_d;
            misaligned_q <= misaligned_d;
            target_q     <= target_d;
            link_q       <= link_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign taken      = taken_q;
    assign illegal    = illegal_q;
    assign misaligned = misaligned_q;
    assign target     = target_q;
    assign link       = link_q;

`ifdef BRANCH_RESOLVER_STATS_EN
    // Only legal conditional branches are counted, at the moment they drain.
    logic        counted_q, counted_d;
    logic [31:0] stat_taken_q, stat_taken_d;
    logic [31:0] stat_not_taken_q, stat_not_taken_d;

    always_comb begin
        counted_d        = accept ? ((op_e'(op) == OP_BRANCH) && !cond_illegal) : counted_q;
        stat_taken_d     = stat_taken_q;
        stat_not_taken_d = stat_not_taken_q;
        if (out_valid_q && out_ready && counted_q) begin
            if (taken_q) begin
                if (stat_taken_q != 32'hFFFF_FFFF)
                    stat_taken_d = stat_taken_q + 32'd1;
            end else begin
                if (stat_not_taken_q != 32'hFFFF_FFFF)
                    stat_not_taken_d = stat_not_taken_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counted_q        <= 1'b0;
            stat_taken_q     <= '0;
            stat_not_taken_q <= '0;
        end else begin
            counted_q        <= counted_d;
            stat_taken_q     <= stat_taken_d;
            stat_not_taken_q <= stat_not_taken_d;
        end
    end

    assign stat_taken     = stat_taken_q;
    assign stat_not_taken = stat_not_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver (WORDSIZE=64); counter checks are active
// when BRANCH_RESOLVER_STATS_EN is defined.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [2:0]  funct3;
    logic [63:0] pc, imm, rs1;
    logic        flag_equal, flag_not_equal, flag_greater, flag_less;
    logic        flag_u_greater, flag_u_less;
    logic        out_valid, out_ready, taken, misaligned, illegal;
    logic [63:0] target, link;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] stat_taken, stat_not_taken;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    branch_resolver #(.WORDSIZE(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .op             (op),
        .funct3         (funct3),
        .pc             (pc),
        .imm            (imm),
        .rs1            (rs1),
        .flag_equal     (flag_equal),
        .flag_not_equal (flag_not_equal),
        .flag_greater   (flag_greater),
        .flag_less      (flag_less),
        .flag_u_greater (flag_u_greater),
        .flag_u_less    (flag_u_less),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .taken          (taken),
        .target         (target),
        .link           (link),
        .misaligned     (misaligned),
`ifdef BRANCH_RESOLVER_STATS_EN
        .stat_taken     (stat_taken),
        .stat_not_taken (stat_not_taken),
`endif
        .illegal        (illegal)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // flags order: {equal, not_equal, greater, less, u_greater, u_less}
    task automatic drive(input logic [1:0] o, input logic [2:0] f3, input logic [63:0] p,
                         input logic [63:0] i, input logic [63:0] r, input logic [5:0] fl);
        in_valid = 1'b1;
        op = o; funct3 = f3; pc = p; imm = i; rs1 = r;
        {flag_equal, flag_not_equal, flag_greater, flag_less, flag_u_greater, flag_u_less} = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic show(input string name);
        $display("txn %-10s valid=%0b taken=%0b target=0x%016h link=0x%016h mis=%0b ill=%0b",
                 name, out_valid, taken, target, link, misaligned, illegal);
    endtask

    task automatic check_result(input string tag, input logic tk, input logic [63:0] tg,
                                input logic [63:0] lk, input logic mis, input logic ill);
        show(tag);
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".taken"}, 64'(taken), 64'(tk));
        check({tag, ".target"}, target, tg);
        check({tag, ".link"}, link, lk);
        check({tag, ".misaligned"}, 64'(misaligned), 64'(mis));
        check({tag, ".illegal"}, 64'(illegal), 64'(ill));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drive(2'b11, 3'b000, 64'h0, 64'h0, 64'h0, 6'b0);
        in_valid = 1'b0;
        tick(); tick();
        show("reset");
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.taken", 64'(taken), 64'd0);
        check("rst.target", target, 64'd0);
        check("rst.link", link, 64'd0);
        check("rst.mis_ill", {62'd0, misaligned, illegal}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst.in_ready", 64'(in_ready), 64'd1);

        // BEQ taken
        drive(2'b00, 3'b000, 64'h1000, 64'h40, 64'h0, 6'b100000);
        tick();
        check_result("beq", 1'b1, 64'h1040, 64'h1004, 1'b0, 1'b0);

        // BGEU with only u_less -> not taken
        drive(2'b00, 3'b111, 64'h2000, 64'h40, 64'h0, 6'b000001);
        tick();
        check_result("bgeu", 1'b0, 64'h2004, 64'h2004, 1'b0, 1'b0);

        // JALR with odd sum: bit0 cleared, still misaligned
        drive(2'b10, 3'b000, 64'h8000, 64'h5, 64'h3001, 6'b000000);
        tick();
        check_result("jalr", 1'b1, 64'h3006, 64'h8004, 1'b1, 1'b0);

        // Reserved funct3 with flag_equal set
        drive(2'b00, 3'b010, 64'h4000, 64'h40, 64'h0, 6'b100000);
        tick();
        check_result("illegal", 1'b0, 64'h4004, 64'h4004, 1'b0, 1'b1);

        // BLT backwards
        drive(2'b00, 3'b100, 64'h100, 64'hFFFF_FFFF_FFFF_FFE0, 64'h0, 6'b000100);
        tick();
        check_result("blt", 1'b1, 64'hE0, 64'h104, 1'b0, 1'b0);

        // BNE with equal operands -> not taken
        drive(2'b00, 3'b001, 64'h200, 64'h80, 64'h0, 6'b100000);
        tick();
        check_result("bne", 1'b0, 64'h204, 64'h204, 1'b0, 1'b0);

        // op none ignores flags
        drive(2'b11, 3'b000, 64'h500, 64'h100, 64'h0, 6'b111111);
        tick();
        check_result("none", 1'b0, 64'h504, 64'h504, 1'b0, 1'b0);

        // JAL wrap-around
        drive(2'b01, 3'b000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8, 64'h0, 6'b000000);
        tick();
        check_result("jal_wrap", 1'b1, 64'h4, 64'h0, 1'b0, 1'b0);

        // Request A, then stall with B pending
        drive(2'b00, 3'b000, 64'h6000, 64'h10, 64'h0, 6'b100000);
        tick();
        check_result("bp_a", 1'b1, 64'h6010, 64'h6004, 1'b0, 1'b0);
        out_ready = 1'b0;
        drive(2'b01, 3'b000, 64'h7000, 64'h20, 64'h0, 6'b000000);
        #1;
        check("bp.in_ready_low", 64'(in_ready), 64'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            show("bp_hold");
            check("bp.hold_ready", 64'(in_ready), 64'd0);
            check("bp.hold_valid", 64'(out_valid), 64'd1);
            check("bp.hold_target", target, 64'h6010);
            check("bp.hold_link", link, 64'h6004);
        end
        out_ready = 1'b1;
        #1;
        check("bp.in_ready_release", 64'(in_ready), 64'd1);
`ifdef BRANCH_RESOLVER_STATS_EN
        check("stat.taken_pre", 64'(stat_taken), 64'd2);
        check("stat.not_taken_pre", 64'(stat_not_taken), 64'd2);
`endif
        tick();
        check_result("bp_b", 1'b1, 64'h7020, 64'h7004, 1'b0, 1'b0);
        in_valid = 1'b0;
        tick();
        show("drain");
        check("drain.valid", 64'(out_valid), 64'd0);
`ifdef BRANCH_RESOLVER_STATS_EN
        check("stat.taken", 64'(stat_taken), 64'd3);
        check("stat.not_taken", 64'(stat_not_taken), 64'd2);
`endif

        // Reset while a result is held
        out_ready = 1'b0;
        drive(2'b00, 3'b000, 64'h9000, 64'h10, 64'h0, 6'b100000);
        tick();
        check("mid.valid_loaded", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        in_valid = 1'b0;
        tick();
        show("mid_rst");
        check("mid.valid", 64'(out_valid), 64'd0);
        check("mid.target", target, 64'd0);
        check("mid.taken", 64'(taken), 64'd0);
`ifdef BRANCH_RESOLVER_STATS_EN
        check("mid.stat_taken", 64'(stat_taken), 64'd0);
        check("mid.stat_not_taken", 64'(stat_not_taken), 64'd0);
`endif
        rst_n = 1'b1;
        tick();
        check("mid.in_ready", 64'(in_ready), 64'd1);
        check("mid.valid_after", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
